// File: rtl/adder4bit_pkg.sv
// adder4bit_pkg: shared constants and result type for the
// registered 4-bit carry-lookahead adder.
package adder4bit_pkg;

  localparam int WIDTH_DEF = 4;

  typedef struct packed {
    logic       cout;
    logic [3:0] sum;
  } res_t;

endpackage

// File: rtl/adder4bit_cla4.sv
// cla4: combinational 4-bit carry-lookahead adder.
// In: a, b, cin. Out: sum, cout, c3 (carry into bit 3).
module cla4
  import adder4bit_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       c3
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is flattened to two logic levels from p/g/cin.
  assign c[0] = cin;
  assign c[1] = g[0]
              | (p[0] & cin);
  assign c[2] = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & cin);
  assign c[3] = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum = p ^ c;
  assign c3  = c[3];

endmodule

// File: rtl/adder4bit.sv
// adder4bit: 1-cycle registered a+b+cin with valid pipeline.
// Ports: clk, rst_n, a, b, cin, sum, cout, in_valid, out_valid,
// plus ovf/zero when ADDER4BIT_FLAGS_EN is defined.
module adder4bit
  import adder4bit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  input  logic             in_valid,
  output logic             out_valid
`ifdef ADDER4BIT_FLAGS_EN
  ,
  output logic             ovf,
  output logic             zero
`endif
);

  res_t res_d;
  res_t res_q;
  logic vld_q;

`ifdef ADDER4BIT_FLAGS_EN
  logic c3;
  logic ovf_q;
  logic zero_q;

  cla4 u_cla (
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (res_d.sum),
    .cout (res_d.cout),
    .c3   (c3)
  );
`else
  cla4 u_cla (
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (res_d.sum),
    .cout (res_d.cout),
    .c3   ()
  );
`endif

  // Result registers only load on valid, so operand
  // values while idle never reach the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) res_q <= res_d;
    end
  end

`ifdef ADDER4BIT_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (in_valid) begin
      ovf_q  <= c3 ^ res_d.cout;
      zero_q <= (res_d.sum == 4'd0);
    end
  end

  assign ovf  = ovf_q;
  assign zero = zero_q;
`endif

  assign sum       = res_q.sum;
  assign cout      = res_q.cout;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_adder4bit.sv
// tb_adder4bit: directed cases, exhaustive sweep and random
// traffic against an arithmetic reference model.
module tb_adder4bit;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] sum;
  logic       cout;
  logic       in_valid;
  logic       out_valid;
`ifdef ADDER4BIT_FLAGS_EN
  logic       ovf;
  logic       zero;
`endif

  int total;
  int bad;

  int m_sum;
  int m_cout;
  int m_v;
  int m_ovf;
  int m_zero;

  adder4bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .cout      (cout),
    .in_valid  (in_valid),
    .out_valid (out_valid)
`ifdef ADDER4BIT_FLAGS_EN
    ,
    .ovf       (ovf),
    .zero      (zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".sum"}, int'(sum), m_sum);
    chk({tag, ".cout"}, int'(cout), m_cout);
    chk({tag, ".vld"}, int'(out_valid), m_v);
`ifdef ADDER4BIT_FLAGS_EN
    chk({tag, ".ovf"}, int'(ovf), m_ovf);
    chk({tag, ".zero"}, int'(zero), m_zero);
`endif
  endtask

  task automatic model_reset();
    m_sum  = 0;
    m_cout = 0;
    m_v    = 0;
    m_ovf  = 0;
    m_zero = 0;
  endtask

  // Advance one clock; model sees the inputs present at the edge.
  task automatic tick(input string tag);
    int s;
    int sa;
    int sb;
    int ss;
    if (in_valid === 1'b1) begin
      s      = int'(a) + int'(b) + int'(cin);
      sa     = a[3] ? int'(a) - 16 : int'(a);
      sb     = b[3] ? int'(b) - 16 : int'(b);
      ss     = sa + sb + int'(cin);
      m_sum  = s % 16;
      m_cout = (s > 15) ? 1 : 0;
      m_v    = 1;
      m_ovf  = (ss > 7 || ss < -8) ? 1 : 0;
      m_zero = (m_sum == 0) ? 1 : 0;
    end else begin
      m_v = 0;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic drive(input int va, input int vb, input int vc,
                       input int vv);
    a        = 4'(va);
    b        = 4'(vb);
    cin      = 1'(vc);
    in_valid = 1'(vv);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    drive(3, 5, 0, 1);
    tick("r025");
    drive(15, 1, 0, 1);
    tick("r026");
    drive(15, 15, 1, 1);
    tick("r027");

    drive(7, 1, 0, 1);
    tick("r028a");
    for (int i = 0; i < 3; i++) begin
      drive(2, 0, 0, 0);
      tick("r028h");
    end

    // Unknown operands while idle must not leak through.
    a        = 4'bxxxx;
    b        = 4'bx0x1;
    cin      = 1'bx;
    in_valid = 1'b0;
    tick("xidle");

    drive(9, 9, 0, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rstnow");
    @(posedge clk);
    #1;
    check_all("rsthold");
    @(negedge clk);
    rst_n = 1'b1;
    drive(9, 9, 0, 0);
    tick("rstrel");

    for (int i = 0; i < 512; i++) begin
      drive((i >> 5) & 15, (i >> 1) & 15, i & 1, 1);
      tick("sweep");
    end

    for (int i = 0; i < 300; i++) begin
      drive(int'($urandom_range(15)), int'($urandom_range(15)),
            int'($urandom_range(1)),
            ($urandom_range(3) != 0) ? 1 : 0);
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
